// File: rtl/core_mem_port_arbiter_if.sv
// Bundle between the requesting ports, the arbiter and the shared memory macro.
// slave = arbiter side, master = requesters plus memory environment.
interface core_mem_port_arbiter_if #(
    parameter int NPORTS = 3,
    parameter int AW     = 32,
    parameter int DW     = 32
);
    localparam int BW = DW / 8;

    logic [NPORTS-1:0]    i_req;
    logic [NPORTS-1:0]    i_we;
    logic [NPORTS-1:0]    i_lock;
    logic [NPORTS*AW-1:0] i_addr;
    logic [NPORTS*DW-1:0] i_wdata;
    logic [NPORTS*BW-1:0] i_be;
    logic [NPORTS-1:0]    o_gnt;
    logic [NPORTS-1:0]    o_stall;
    logic [NPORTS-1:0]    o_rvalid;
    logic [DW-1:0]        o_rdata;
    logic                 o_mem_en;
    logic                 o_mem_we;
    logic [AW-1:0]        o_mem_addr;
    logic [BW-1:0]        o_mem_be;
    logic [DW-1:0]        o_mem_wdata;
    logic [DW-1:0]        i_mem_rdata;

    modport slave (
        input  i_req, i_we, i_lock, i_addr, i_wdata, i_be, i_mem_rdata,
        output o_gnt, o_stall, o_rvalid, o_rdata,
        output o_mem_en, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata
    );

    modport master (
        output i_req, i_we, i_lock, i_addr, i_wdata, i_be, i_mem_rdata,
        input  o_gnt, o_stall, o_rvalid, o_rdata,
        input  o_mem_en, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata
    );
endinterface

// File: rtl/core_mem_port_arbiter.sv
// Shares one single-ported synchronous memory between NPORTS requesters using
// fixed priority or round-robin, with per-port burst lock and read-data return.
module core_mem_port_arbiter #(
    parameter int NPORTS  = 3,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int RR_MODE = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clk_en,
    core_mem_port_arbiter_if.slave bus
);
    localparam int            BW   = DW / 8;
    localparam int            PW   = $clog2(NPORTS);
    localparam logic [PW:0]   NP   = (PW+1)'(NPORTS);
    localparam logic [PW-1:0] LAST = PW'(NPORTS - 1);

    logic [PW-1:0]     ptr_q, ptr_d;
    logic              lock_vld_q, lock_vld_d;
    logic [PW-1:0]     lock_id_q, lock_id_d;
    logic [NPORTS-1:0] rvalid_q, rvalid_d;
    logic [DW-1:0]     rdata_q, rdata_d;

    logic              found;
    logic [PW-1:0]     sel;
    logic [PW-1:0]     start;
    logic [PW:0]       cand;
    logic [NPORTS-1:0] gnt;

    logic [AW-1:0] addr_a  [NPORTS];
    logic [DW-1:0] wdata_a [NPORTS];
    logic [BW-1:0] be_a    [NPORTS];

    for (genvar g = 0; g < NPORTS; g++) begin : g_unpack
        assign addr_a[g]  = bus.i_addr[g*AW +: AW];
        assign wdata_a[g] = bus.i_wdata[g*DW +: DW];
        assign be_a[g]    = bus.i_be[g*BW +: BW];
    end

    // A live lock owner pre-empts the search; otherwise scan from start with wrap.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        start = (RR_MODE != 0) ? ptr_q : '0;
        if (!i_rst && i_clk_en) begin
            if (lock_vld_q && bus.i_req[lock_id_q]) begin
                found = 1'b1;
                sel   = lock_id_q;
            end else begin
                for (int k = 0; k < NPORTS; k++) begin
                    cand = {1'b0, start} + (PW+1)'(k);
                    if (cand >= NP) cand = cand - NP;
                    if (!found && bus.i_req[cand[PW-1:0]]) begin
                        found = 1'b1;
                        sel   = cand[PW-1:0];
                    end
                end
            end
        end
    end

    assign gnt             = found ? (NPORTS'(1) << sel) : '0;
    assign bus.o_gnt       = gnt;
    assign bus.o_stall     = bus.i_req & ~gnt;
    assign bus.o_mem_en    = found;
    assign bus.o_mem_we    = found && bus.i_we[sel];
    assign bus.o_mem_addr  = found ? addr_a[sel] : '0;
    assign bus.o_mem_wdata = found ? wdata_a[sel] : '0;
    assign bus.o_mem_be    = (found && bus.i_we[sel]) ? be_a[sel] : '0;

    assign ptr_d      = found ? ((sel == LAST) ? '0 : sel + 1'b1) : ptr_q;
    assign lock_vld_d = found && bus.i_lock[sel];
    assign lock_id_d  = found ? sel : lock_id_q;
    assign rvalid_d   = (found && !bus.i_we[sel]) ? gnt : '0;
    assign rdata_d    = (rvalid_q != '0) ? bus.i_mem_rdata : rdata_q;

    // Memory output is live while a read is owned; rdata_q keeps the last shown word.
    assign bus.o_rvalid = rvalid_q;
    assign bus.o_rdata  = (rvalid_q != '0) ? bus.i_mem_rdata : rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q      <= '0;
            lock_vld_q <= 1'b0;
            lock_id_q  <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
        end else if (i_clk_en) begin
            ptr_q      <= ptr_d;
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end
endmodule

// File: tb/tb_core_mem_port_arbiter.sv
// Bench for core_mem_port_arbiter: fixed-priority and round-robin instances driven
// with identical stimulus, checked against directed vectors and a behavioural model.
module tb_core_mem_port_arbiter;
    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, clk_en;
    logic [N-1:0] req, we, lock;
    logic [31:0]  addr  [N];
    logic [31:0]  wdata [N];
    logic [3:0]   be    [N];

    core_mem_port_arbiter_if #(.NPORTS(N), .AW(32), .DW(32)) if_fp ();
    core_mem_port_arbiter_if #(.NPORTS(N), .AW(32), .DW(32)) if_rr ();

    core_mem_port_arbiter #(.NPORTS(N), .AW(32), .DW(32), .RR_MODE(0)) dut_fp (
        .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .bus(if_fp.slave));
    core_mem_port_arbiter #(.NPORTS(N), .AW(32), .DW(32), .RR_MODE(1)) dut_rr (
        .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .bus(if_rr.slave));

    assign if_fp.i_req  = req;
    assign if_fp.i_we   = we;
    assign if_fp.i_lock = lock;
    assign if_rr.i_req  = req;
    assign if_rr.i_we   = we;
    assign if_rr.i_lock = lock;
    for (genvar g = 0; g < N; g++) begin : g_drv
        assign if_fp.i_addr[g*32 +: 32]  = addr[g];
        assign if_fp.i_wdata[g*32 +: 32] = wdata[g];
        assign if_fp.i_be[g*4 +: 4]      = be[g];
        assign if_rr.i_addr[g*32 +: 32]  = addr[g];
        assign if_rr.i_wdata[g*32 +: 32] = wdata[g];
        assign if_rr.i_be[g*4 +: 4]      = be[g];
    end

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] bm);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (bm[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Synchronous RAMs behind each DUT: output register only updates on an enabled read.
    logic [31:0] ram_fp [16];
    logic [31:0] ram_rr [16];
    logic [31:0] ram_q_fp, ram_q_rr;
    assign if_fp.i_mem_rdata = ram_q_fp;
    assign if_rr.i_mem_rdata = ram_q_rr;

    always @(posedge clk) begin
        if (clk_en && if_fp.o_mem_en) begin
            if (if_fp.o_mem_we)
                ram_fp[if_fp.o_mem_addr[5:2]] <= merge(ram_fp[if_fp.o_mem_addr[5:2]], if_fp.o_mem_wdata, if_fp.o_mem_be);
            else
                ram_q_fp <= ram_fp[if_fp.o_mem_addr[5:2]];
        end
    end

    always @(posedge clk) begin
        if (clk_en && if_rr.o_mem_en) begin
            if (if_rr.o_mem_we)
                ram_rr[if_rr.o_mem_addr[5:2]] <= merge(ram_rr[if_rr.o_mem_addr[5:2]], if_rr.o_mem_wdata, if_rr.o_mem_be);
            else
                ram_q_rr <= ram_rr[if_rr.o_mem_addr[5:2]];
        end
    end

    // Reference model state, index 0 = fixed priority, 1 = round-robin.
    int          ptr_m [2] = '{0, 0};
    bit          lkv   [2] = '{0, 0};
    int          lkid  [2] = '{0, 0};
    logic [2:0]  exp_rv [2] = '{3'b000, 3'b000};
    logic [31:0] exp_rd [2] = '{32'h0, 32'h0};
    logic [31:0] shadow [2][16];
    string       nm [2] = '{"fp", "rr"};

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s (cycle %0d): got %h, want %h", name, cyc, act, exp);
        else n_pass++;
    endtask

    function automatic int pick(int m);
        int s, p;
        if (rst || !clk_en) return -1;
        if (lkv[m] && req[lkid[m]]) return lkid[m];
        s = (m == 1) ? ptr_m[m] : 0;
        for (int off = 0; off < N; off++) begin
            p = (s + off) % N;
            if (req[p]) return p;
        end
        return -1;
    endfunction

    task automatic check_dut(int m, logic [2:0] gnt, logic [2:0] stall, logic [2:0] rv,
                             logic [31:0] rd, logic men, logic mwe, logic [31:0] maddr,
                             logic [3:0] mbe, logic [31:0] mwd);
        int p;
        logic [2:0] e_g;
        logic e_en, e_we;
        logic [31:0] e_addr, e_wd;
        logic [3:0] e_be;
        p = pick(m);
        e_g = 3'b000; e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0; e_be = '0;
        if (p >= 0) begin
            e_g    = 3'b001 << p;
            e_en   = 1'b1;
            e_we   = we[p];
            e_addr = addr[p];
            e_wd   = wdata[p];
            e_be   = we[p] ? be[p] : 4'h0;
        end
        chk({nm[m], " gnt"},       gnt,   e_g);
        chk({nm[m], " stall"},     stall, req & ~e_g);
        chk({nm[m], " rvalid"},    rv,    exp_rv[m]);
        chk({nm[m], " rdata"},     rd,    exp_rd[m]);
        chk({nm[m], " mem_en"},    men,   e_en);
        chk({nm[m], " mem_we"},    mwe,   e_we);
        chk({nm[m], " mem_addr"},  maddr, e_addr);
        chk({nm[m], " mem_be"},    mbe,   e_be);
        chk({nm[m], " mem_wdata"}, mwd,   e_wd);
    endtask

    task automatic model_step(int m);
        int p;
        p = pick(m);
        if (rst) begin
            ptr_m[m] = 0; lkv[m] = 0; lkid[m] = 0; exp_rv[m] = '0; exp_rd[m] = '0;
        end else if (clk_en) begin
            exp_rv[m] = '0;
            lkv[m]    = 0;
            if (p >= 0) begin
                ptr_m[m] = (p + 1) % N;
                if (lock[p]) begin lkv[m] = 1; lkid[m] = p; end
                if (we[p])
                    shadow[m][addr[p][5:2]] = merge(shadow[m][addr[p][5:2]], wdata[p], be[p]);
                else begin
                    exp_rv[m] = 3'b001 << p;
                    exp_rd[m] = shadow[m][addr[p][5:2]];
                end
            end
        end
    endtask

    task automatic settle_and_check();
        @(negedge clk);
        check_dut(0, if_fp.o_gnt, if_fp.o_stall, if_fp.o_rvalid, if_fp.o_rdata, if_fp.o_mem_en,
                  if_fp.o_mem_we, if_fp.o_mem_addr, if_fp.o_mem_be, if_fp.o_mem_wdata);
        check_dut(1, if_rr.o_gnt, if_rr.o_stall, if_rr.o_rvalid, if_rr.o_rdata, if_rr.o_mem_en,
                  if_rr.o_mem_we, if_rr.o_mem_addr, if_rr.o_mem_be, if_rr.o_mem_wdata);
    endtask

    task automatic advance();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_cycle();
        settle_and_check();
        advance();
    endtask

    typedef struct packed {
        logic       rst;
        logic       en;
        logic [2:0] req;
        logic [2:0] lock;
        logic [2:0] gfp;
        logic [2:0] grr;
        logic [2:0] rvf;
        logic [2:0] rvr;
    } vec_t;

    vec_t tbl [25];

    initial begin
        // rst, en, req, lock, exp gnt fp, exp gnt rr, exp rvalid fp, exp rvalid rr
        tbl[0]  = {1'b0, 1'b1, 3'b111, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000};
        tbl[1]  = {1'b0, 1'b1, 3'b111, 3'b000, 3'b001, 3'b010, 3'b001, 3'b001};
        tbl[2]  = {1'b0, 1'b1, 3'b111, 3'b000, 3'b001, 3'b100, 3'b001, 3'b010};
        tbl[3]  = {1'b0, 1'b1, 3'b111, 3'b000, 3'b001, 3'b001, 3'b001, 3'b100};
        tbl[4]  = {1'b0, 1'b1, 3'b111, 3'b000, 3'b001, 3'b010, 3'b001, 3'b001};
        tbl[5]  = {1'b0, 1'b1, 3'b111, 3'b000, 3'b001, 3'b100, 3'b001, 3'b010};
        tbl[6]  = {1'b0, 1'b1, 3'b011, 3'b000, 3'b001, 3'b001, 3'b001, 3'b100};
        tbl[7]  = {1'b0, 1'b1, 3'b011, 3'b000, 3'b001, 3'b010, 3'b001, 3'b001};
        tbl[8]  = {1'b0, 1'b1, 3'b111, 3'b100, 3'b001, 3'b100, 3'b001, 3'b010};
        tbl[9]  = {1'b0, 1'b1, 3'b111, 3'b100, 3'b001, 3'b100, 3'b001, 3'b100};
        tbl[10] = {1'b0, 1'b1, 3'b111, 3'b100, 3'b001, 3'b100, 3'b001, 3'b100};
        tbl[11] = {1'b0, 1'b1, 3'b011, 3'b000, 3'b001, 3'b001, 3'b001, 3'b100};
        tbl[12] = {1'b0, 1'b1, 3'b111, 3'b000, 3'b001, 3'b010, 3'b001, 3'b001};
        tbl[13] = {1'b0, 1'b0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b001, 3'b010};
        tbl[14] = {1'b0, 1'b0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b001, 3'b010};
        tbl[15] = {1'b0, 1'b1, 3'b111, 3'b000, 3'b001, 3'b100, 3'b001, 3'b010};
        tbl[16] = {1'b0, 1'b1, 3'b111, 3'b000, 3'b001, 3'b001, 3'b001, 3'b100};
        tbl[17] = {1'b1, 1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001};
        tbl[18] = {1'b0, 1'b1, 3'b111, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000};
        tbl[19] = {1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001};
        tbl[20] = {1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        tbl[21] = {1'b0, 1'b1, 3'b111, 3'b000, 3'b001, 3'b010, 3'b000, 3'b000};
        tbl[22] = {1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b010};
        tbl[23] = {1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        tbl[24] = {1'b0, 1'b1, 3'b111, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000};

        for (int i = 0; i < 16; i++) begin
            ram_fp[i]    <= 32'hA5A5_0000 | i;
            ram_rr[i]    <= 32'hA5A5_0000 | i;
            shadow[0][i] = 32'hA5A5_0000 | i;
            shadow[1][i] = 32'hA5A5_0000 | i;
        end
        ram_q_fp <= '0;
        ram_q_rr <= '0;

        rst = 1'b1; clk_en = 1'b1; req = '0; we = '0; lock = '0;
        for (int p = 0; p < N; p++) begin
            addr[p] = 32'h10 * (p + 1); wdata[p] = 32'h1111_0000 + p; be[p] = 4'h0;
        end
        run_cycle();
        run_cycle();

        for (int i = 0; i < 25; i++) begin
            rst = tbl[i].rst; clk_en = tbl[i].en; req = tbl[i].req; lock = tbl[i].lock; we = '0;
            settle_and_check();
            chk($sformatf("tbl%0d fp gnt", i),    if_fp.o_gnt,    tbl[i].gfp);
            chk($sformatf("tbl%0d rr gnt", i),    if_rr.o_gnt,    tbl[i].grr);
            chk($sformatf("tbl%0d fp rvalid", i), if_fp.o_rvalid, tbl[i].rvf);
            chk($sformatf("tbl%0d rr rvalid", i), if_rr.o_rvalid, tbl[i].rvr);
            advance();
        end

        // Partial write then read-back of the same word through a different port.
        rst = 1'b0; clk_en = 1'b1; req = '0; we = '0; lock = '0;
        run_cycle();
        req = 3'b010; we = 3'b010; addr[1] = 32'h20; wdata[1] = 32'hDEADBEEF; be[1] = 4'b0011;
        settle_and_check();
        chk("wr fp mem_we",   if_fp.o_mem_we,   1);
        chk("wr fp mem_be",   if_fp.o_mem_be,   4'b0011);
        chk("wr rr mem_we",   if_rr.o_mem_we,   1);
        chk("wr rr mem_be",   if_rr.o_mem_be,   4'b0011);
        chk("wr rr mem_addr", if_rr.o_mem_addr, 32'h20);
        advance();
        req = 3'b100; we = 3'b000; addr[2] = 32'h20;
        run_cycle();
        req = 3'b000;
        settle_and_check();
        chk("rd fp rvalid", if_fp.o_rvalid, 3'b100);
        chk("rd fp rdata",  if_fp.o_rdata,  32'hA5A5_BEEF);
        chk("rd rr rvalid", if_rr.o_rvalid, 3'b100);
        chk("rd rr rdata",  if_rr.o_rdata,  32'hA5A5_BEEF);
        advance();

        for (int c = 0; c < 600; c++) begin
            rst    = ($urandom_range(0, 99) < 3);
            clk_en = ($urandom_range(0, 99) < 85);
            req    = 3'($urandom);
            we     = 3'($urandom);
            lock   = 3'($urandom) & 3'($urandom);
            for (int p = 0; p < N; p++) begin
                addr[p]  = {26'b0, 4'($urandom), 2'b00};
                wdata[p] = $urandom;
                be[p]    = 4'($urandom);
            end
            run_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
